// File: rtl/text_pixel_pipeline_if.sv
`timescale 1ns/1ps
// Pixel-side bus of the text renderer: timing-generator inputs, VRAM/font read ports and video outputs.
// The slave modport is the renderer; the master modport is the surrounding controller.
interface text_pixel_pipeline_if;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        hsync_i;
  logic        vsync_i;
  logic        vde_i;
  logic [31:0] ctrl;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync_o;
  logic        vsync_o;
  logic        vde_o;

  modport slave (
    input  drawX, drawY, hsync_i, vsync_i, vde_i, ctrl, vram_rdata, font_data,
    output vram_addr, font_addr, red, green, blue, hsync_o, vsync_o, vde_o
  );

  modport master (
    output drawX, drawY, hsync_i, vsync_i, vde_i, ctrl, vram_rdata, font_data,
    input  vram_addr, font_addr, red, green, blue, hsync_o, vsync_o, vde_o
  );
endinterface

// File: rtl/text_pixel_pipeline.sv
`timescale 1ns/1ps
// 80x30 text-mode renderer with a fixed 3-cycle latency from timing inputs to RGB and syncs.
// Optional feature macro TEXT_BLINK_EN: inverse-video characters blink with a 64-frame period.
module text_pixel_pipeline #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input logic                  pixel_clk,
  input logic                  arstn,
  text_pixel_pipeline_if.slave bus
);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;
  logic [11:0]      idx_s;
  logic [7:0]       char_s;
  logic [11:0]      fg_s;
  logic [11:0]      bg_s;
  logic             pix_on_s;
  logic             blink_off_s;
  logic             vsync_fall_s;
  logic             unused_s;

  logic [9:0]  vram_addr_q, vram_addr_d;
  logic [1:0]  byte_sel_q, byte_sel_d;
  logic [2:0]  pix_x0_q, pix_x0_d;
  logic [3:0]  glyph_row_q, glyph_row_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic        inv_q, inv_d;
  logic [2:0]  pix_x1_q, pix_x1_d;
  logic [11:0] rgb_q, rgb_d;
  logic [2:0]  hs_pipe_q, hs_pipe_d;
  logic [2:0]  vs_pipe_q, vs_pipe_d;
  logic [2:0]  vde_pipe_q, vde_pipe_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [31:0] ctrl_latched_q, ctrl_latched_d;
`ifdef TEXT_BLINK_EN
  logic [5:0]  blink_cnt_q, blink_cnt_d;
`endif

  // S0: character cell index row*80+col split into VRAM word and byte lane
  always_comb begin
    col_s       = bus.drawX[3 +: COL_W];
    row_s       = bus.drawY[4 +: ROW_W];
    idx_s       = (12'(row_s) << 6) + (12'(row_s) << 4) + 12'(col_s);
    vram_addr_d = idx_s[11:2];
    byte_sel_d  = idx_s[1:0];
    pix_x0_d    = bus.drawX[2:0];
    glyph_row_d = bus.drawY[3:0];
  end

  // S1: pick the character byte and form the font ROM address
  always_comb begin
    case (byte_sel_q)
      2'd0:    char_s = bus.vram_rdata[7:0];
      2'd1:    char_s = bus.vram_rdata[15:8];
      2'd2:    char_s = bus.vram_rdata[23:16];
      default: char_s = bus.vram_rdata[31:24];
    endcase
    inv_d       = char_s[7];
    font_addr_d = {char_s[6:0], glyph_row_q};
    pix_x1_d    = pix_x0_q;
  end

  // S2: glyph bit, inversion/blink and colour select; vde_pipe_q[1] is this pixel's enable
  always_comb begin
    fg_s = ctrl_latched_q[24:13];
    bg_s = ctrl_latched_q[12:1];
`ifdef TEXT_BLINK_EN
    blink_off_s = inv_q & blink_cnt_q[5];
`else
    blink_off_s = 1'b0;
`endif
    pix_on_s = (bus.font_data[3'd7 - pix_x1_q] ^ inv_q) & ~blink_off_s;
    if (!vde_pipe_q[1]) begin
      rgb_d = 12'h000;
    end else if (pix_on_s) begin
      rgb_d = fg_s;
    end else begin
      rgb_d = bg_s;
    end
  end

  // Sync delay lines and the once-per-frame control capture on the vsync falling edge
  always_comb begin
    hs_pipe_d    = {hs_pipe_q[1:0], bus.hsync_i};
    vs_pipe_d    = {vs_pipe_q[1:0], bus.vsync_i};
    vde_pipe_d   = {vde_pipe_q[1:0], bus.vde_i};
    vsync_prev_d = bus.vsync_i;
    vsync_fall_s = vsync_prev_q & ~bus.vsync_i;
    if (vsync_fall_s) begin
      ctrl_latched_d = bus.ctrl;
    end else begin
      ctrl_latched_d = ctrl_latched_q;
    end
`ifdef TEXT_BLINK_EN
    if (vsync_fall_s) begin
      blink_cnt_d = blink_cnt_q + 6'd1;
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
`endif
  end

  // Edge detector follows vsync_i even in reset so a low vsync at release is not seen as a fall
  always_ff @(posedge pixel_clk) begin
    vsync_prev_q <= vsync_prev_d;
  end

  // Pipeline and frame state registers with synchronous active-low reset
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      vram_addr_q    <= 10'd0;
      byte_sel_q     <= 2'd0;
      pix_x0_q       <= 3'd0;
      glyph_row_q    <= 4'd0;
      font_addr_q    <= 11'd0;
      inv_q          <= 1'b0;
      pix_x1_q       <= 3'd0;
      rgb_q          <= 12'h000;
      hs_pipe_q      <= 3'b111;
      vs_pipe_q      <= 3'b111;
      vde_pipe_q     <= 3'b000;
      ctrl_latched_q <= CTRL_RESET;
`ifdef TEXT_BLINK_EN
      blink_cnt_q    <= 6'd0;
`endif
    end else begin
      vram_addr_q    <= vram_addr_d;
      byte_sel_q     <= byte_sel_d;
      pix_x0_q       <= pix_x0_d;
      glyph_row_q    <= glyph_row_d;
      font_addr_q    <= font_addr_d;
      inv_q          <= inv_d;
      pix_x1_q       <= pix_x1_d;
      rgb_q          <= rgb_d;
      hs_pipe_q      <= hs_pipe_d;
      vs_pipe_q      <= vs_pipe_d;
      vde_pipe_q     <= vde_pipe_d;
      ctrl_latched_q <= ctrl_latched_d;
`ifdef TEXT_BLINK_EN
      blink_cnt_q    <= blink_cnt_d;
`endif
    end
  end

  assign bus.vram_addr = vram_addr_q;
  assign bus.font_addr = font_addr_q;
  assign bus.red       = rgb_q[11:8];
  assign bus.green     = rgb_q[7:4];
  assign bus.blue      = rgb_q[3:0];
  assign bus.hsync_o   = hs_pipe_q[2];
  assign bus.vsync_o   = vs_pipe_q[2];
  assign bus.vde_o     = vde_pipe_q[2];

  assign unused_s = ^{bus.drawY[9], ctrl_latched_q[31:25], ctrl_latched_q[0]};
endmodule

// File: doc/text_pixel_pipeline.md
Name: text_pixel_pipeline

Overview:
- Renders the 80x30 text screen inside hdmi_text_controller, between the VGA timing generator and the HDMI encoder.
- Consumes drawX/drawY/hsync/vsync/vde from the timing generator and reads character bytes from the VRAM read port and glyph rows from the font ROM.
- Produces 4-bit R/G/B plus hsync/vsync/vde, delayed to stay aligned with the pixels.
- Fixed 3-cycle pipeline; the colour control register is latched once per frame so colours never change mid-frame.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, character rows.
- CTRL_RESET, 32'h0, reset value of the frame-latched control copy.

Ports:
- pixel_clk  in  1  pixel clock (25 MHz).
- arstn  in  1  reset, synchronous, active-low; clock pixel_clk.
- drawX  in  10  current pixel column from the timing generator.
- drawY  in  10  current pixel row.
- hsync_i  in  1  active-low horizontal sync from the timing generator.
- vsync_i  in  1  active-low vertical sync from the timing generator.
- vde_i  in  1  video data enable (not blanking).
- ctrl  in  32  live control register (VRAM word 600); fg = ctrl[24:13], bg = ctrl[12:1], each 12 bits as {R,G,B}.
- vram_addr  out  10  VRAM word address, 0..599.
- vram_rdata  in  32  VRAM data, valid 1 cycle after vram_addr.
- font_addr  out  11  {glyph[6:0], glyph_row[3:0]}.
- font_data  in  8  font ROM row, valid 1 cycle after font_addr; bit 7 is the leftmost pixel.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- hsync_o  out  1  hsync_i delayed 3 cycles.
- vsync_o  out  1  vsync_i delayed 3 cycles.
- vde_o  out  1  vde_i delayed 3 cycles.

Behaviour:
- Address math, stage S0 (registered into vram_addr):
  - col = drawX[9:3], row = drawY[8:4].
  - idx = row*80 + col, computed as (row<<6)+(row<<4)+col, 12 bits.
  - vram_addr = idx[11:2]; byte_sel = idx[1:0]; byte 0 = bits [7:0], byte 3 = bits [31:24].
  - Also registers pix_x = drawX[2:0] and glyph_row = drawY[3:0].
- S1:
  - Select char byte from vram_rdata using the delayed byte_sel.
  - inv = char[7].
  - font_addr = {char[6:0], glyph_row}, registered.
- S2:
  - bit = font_data[7 - pix_x], using the delayed pix_x.
  - on = bit XOR inv.
  - Colour = on ? fg : bg, taken from the latched ctrl copy.
  - Registered into red/green/blue.
- Blanking: if the delayed vde is 0, RGB = 0.
- Latency: RGB, hsync_o, vsync_o and vde_o all change exactly 3 pixel_clk cycles after the corresponding inputs, with no pixel-to-sync skew.
- Frame latch:
  - ctrl_latched <= ctrl on the cycle vsync_i falls (edge detect against a registered vsync_i).
  - Held for the whole frame.
  - A ctrl write mid-frame takes effect only at the next vsync fall.
- Out of range (drawX ≥ 640 or drawY ≥ 480): vde_i is 0 there. vram_addr may exceed 599; the result is ignored because RGB is forced to 0.
- Reset (arstn = 0 at a pixel_clk edge):
  - RGB = 0; vde pipe = 0.
  - hsync/vsync pipes = 1 (inactive); hsync_o = vsync_o = 1.
  - vram_addr = 0; font_addr = 0.
  - ctrl_latched = CTRL_RESET; blink counter = 0.
- Reset mid-frame: pipeline flushes fully. The first valid pixel appears 3 cycles after release, and ctrl_latched stays CTRL_RESET until the next vsync fall.
- Simultaneous vsync fall and ctrl change: the value of ctrl present on that cycle is the one latched.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- Defined:
  - A 6-bit frame counter increments on each vsync_i fall and wraps 63→0.
  - When counter[5] = 1, characters with inv = 1 render entirely as bg (blink off phase).
  - When counter[5] = 0, they render inverted as usual.
  - Period is 64 frames, 32 on / 32 off.
  - Counter resets to 0.
- Undefined: no counter; inverted characters are always shown inverted.

Test Plan:
- Reset behaviour: hold arstn = 0 for 4 cycles → RGB = 0, hsync_o = vsync_o = 1, vde_o = 0, vram_addr = 0.
- Address mapping: drawX = 8, drawY = 0 → vram_addr = 0, byte_sel = 1. drawX = 639, drawY = 479 → idx = 2399, vram_addr = 599, byte_sel = 3.
- Pixel render: ctrl latched = 32'h001F6000, VRAM word 0 = 32'h00000041, font row for 0x41 = 8'h18, drawY = 0, drawX = 0..7 → output pixels 3..4 = fg, others = bg, each appearing 3 cycles after its drawX.
- Inverse glyph: char = 8'hC1, same font row 8'h18 → pixels 3..4 = bg, others = fg.
- Frame latch: change ctrl mid-frame → RGB colours unchanged until the cycle after the vsync_i fall propagates; then the new fg/bg appear. vsync_o falls exactly 3 cycles after vsync_i.
- Blink (TEXT_BLINK_EN defined): char 8'hC1, run 33 vsync falls → frames 0–31 shown inverted, frame 32 shows all bg.
